// File: rtl/qspi_pkg.sv
// Shared constants, state encoding and helpers for the QPI memory controller.
// No logic; pure declarations.
// Imported by qspi_mem_ctrl and qspi_sclk_gen.
package qspi_pkg;

  localparam logic [7:0] QSPI_OP_READ  = 8'hEB;
  localparam logic [7:0] QSPI_OP_WRITE = 8'h38;

  localparam logic [3:0] NIBBLES_CMD  = 4'd2;
  localparam logic [3:0] NIBBLES_ADDR = 4'd6;
  localparam logic [3:0] NIBBLES_DATA = 4'd8;

  // Chip-select code with no device behind it
  localparam logic [1:0] SEL_UNMAPPED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_GAP
  } qspi_state_e;

  // Wire order is byte0 first; this maps a word to/from that stream order
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_sclk_gen.sv
// SPI clock divider: mode-0 spi_clk (low half first) plus a strobe on the edge that ends each high half.
// Latency: first low half starts the cycle en_i rises; each half lasts CLK_DIV clocks.
// Backpressure: none; free-runs while en_i is high, parks low/reset while en_i is low.
module qspi_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic spi_clk_o,
  output logic fall_o
);
  import qspi_pkg::*;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       half_end;

  assign half_end = (cnt_q == HALF_LAST);

  // Count out each half period and toggle the phase at its end; idle parks low
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_end) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign spi_clk_o = phase_q;
  assign fall_o    = en_i & phase_q & half_end;

endmodule

// File: rtl/qspi_mem_ctrl.sv
// QPI master: turns single-word core read/write requests into 4-bit wire transactions on CS0..CS2.
// Latency: (16+WAIT_CYCLES)*2*CLK_DIV+1 clocks read, 32*CLK_DIV+1 write, 1 for unmapped select.
// Backpressure: req_ready high only in IDLE; one request in flight, CS held high CS_HIGH_MIN clocks after.
module qspi_mem_ctrl #(
  parameter int CLK_DIV     = 1,
  parameter int WAIT_CYCLES = 6,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_sel,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        spi_clk,
  output logic        cs0,
  output logic        cs1,
  output logic        cs2,
  output logic [3:0]  out_sio,
  input  logic [3:0]  in_sio,
  output logic        dir
);
  import qspi_pkg::*;

  localparam logic [3:0] LAST_DUMMY = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [7:0] GAP_LAST   = 8'(CS_HIGH_MIN - 1);

  qspi_state_e state_q, state_d;
  logic [3:0]  nib_cnt_q, nib_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;
  logic [63:0] tx_q, tx_d;
  logic [27:0] rx_q, rx_d;
  logic [31:0] rx_shift;
  logic        rdy_q, rdy_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rdata_q, rdata_d;
  logic        active;
  logic        sclk_fall;

  assign active = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                  (state_q == ST_DUMMY) || (state_q == ST_DATA);

  qspi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clock    (clock),
    .reset    (reset),
    .en_i     (active),
    .spi_clk_o(spi_clk),
    .fall_o   (sclk_fall)
  );

  // Incoming read nibble appended to what has been collected so far
  assign rx_shift = {rx_q, in_sio};

  // Next-state, nibble sequencing, shifting and response generation
  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    gap_cnt_d = gap_cnt_q;
    we_d      = we_q;
    sel_d     = sel_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rsp_vld_d = 1'b0;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && rdy_q) begin
          we_d  = req_we;
          sel_d = req_sel;
          if (req_sel == SEL_UNMAPPED) begin
            // No device: answer immediately, never touch the bus
            rsp_vld_d = 1'b1;
            if (!req_we) rdata_d = 32'hFFFF_FFFF;
          end else begin
            tx_d      = {req_we ? QSPI_OP_WRITE : QSPI_OP_READ, req_addr,
                         req_we ? bswap32(req_wdata) : 32'h0};
            nib_cnt_d = '0;
            state_d   = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (sclk_fall) begin
          tx_d = {tx_q[59:0], 4'h0};
          if (nib_cnt_q == NIBBLES_CMD - 4'd1) begin
            nib_cnt_d = '0;
            state_d   = ST_ADDR;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
      end
      ST_ADDR: begin
        if (sclk_fall) begin
          tx_d = {tx_q[59:0], 4'h0};
          if (nib_cnt_q == NIBBLES_ADDR - 4'd1) begin
            nib_cnt_d = '0;
            state_d   = (!we_q && WAIT_CYCLES > 0) ? ST_DUMMY : ST_DATA;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
      end
      ST_DUMMY: begin
        if (sclk_fall) begin
          if (nib_cnt_q == LAST_DUMMY) begin
            nib_cnt_d = '0;
            state_d   = ST_DATA;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (sclk_fall) begin
          tx_d = {tx_q[59:0], 4'h0};
          if (!we_q) rx_d = rx_shift[27:0];
          if (nib_cnt_q == NIBBLES_DATA - 4'd1) begin
            nib_cnt_d = '0;
            gap_cnt_d = '0;
            rsp_vld_d = 1'b1;
            if (!we_q) rdata_d = bswap32(rx_shift);
            state_d   = ST_GAP;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      nib_cnt_q <= '0;
      gap_cnt_q <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdy_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdy_q     <= rdy_d;
      rsp_vld_q <= rsp_vld_d;
      rdata_q   <= rdata_d;
    end
  end

  // Controller owns the pads for command, address and write data only
  assign dir       = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     ((state_q == ST_DATA) && we_q);
  assign out_sio   = dir ? tx_q[63:60] : 4'h0;
  assign cs0       = ~(active && (sel_q == 2'd0));
  assign cs1       = ~(active && (sel_q == 2'd1));
  assign cs2       = ~(active && (sel_q == 2'd2));
  assign req_ready = rdy_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_rdata = rdata_q;

endmodule
